fn_sw_4_id: RTL and testbench

Sequential function identifier for the `fn_sw_4` two-input logic unit. It watches a stream of (a, b, y) samples taken from a `fn_sw_4` instance whose `sel` is unknown, and narrows down which of the four functions is active. It then reports the decoded 2-bit select, or an error if no single function fits. It sits on the observation side of the logic unit, for self-check and bring-up benches and for on-chip consistency monitors.

---
 rtl/fn_sw_4_id.sv | 96 +++++++++
 tb/tb_fn_sw_4_id.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fn_sw_4_id.sv
// Sequential identifier for the fn_sw_4 logic unit: narrows AND/OR/XOR/XNOR
// candidates from observed (a, b, y) samples and reports the decoded select.
module fn_sw_4_id #(
    parameter int MAX_SMP = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       vld,
    input  logic       a,
    input  logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] sel_out,
    output logic [3:0] cand,
    output logic [3:0] cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_SMP);

    state_t     state, state_n;
    logic [3:0] m;
    logic [3:0] cand_m;
    logic [3:0] cand_n;
    logic [3:0] cnt_n;
    logic [1:0] sel_n;
    logic       onehot;

    // Narrow the candidate set with each accepted sample; start always wins.
    always_comb begin
        m[0]    = ((a & b) == y);
        m[1]    = ((a | b) == y);
        m[2]    = ((a ^ b) == y);
        m[3]    = (~(a ^ b) == y);
        cand_m  = cand & m;
        onehot  = (cand_m != 4'b0000) && ((cand_m & (cand_m - 4'd1)) == 4'b0000);
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        sel_n   = sel_out;

        if (start) begin
            state_n = SCAN;
            cand_n  = 4'b1111;
            cnt_n   = 4'd0;
            sel_n   = 2'b00;
        end else if (state == SCAN && vld) begin
            cand_n = cand_m;
            cnt_n  = cnt + 4'd1;
            if (onehot) begin
                state_n = DONE;
                case (cand_m)
                    4'b0010: sel_n = 2'b01;
                    4'b0100: sel_n = 2'b10;
                    4'b1000: sel_n = 2'b11;
                    default: sel_n = 2'b00;
                endcase
            end else if (cand_m == 4'b0000) begin
                state_n = ERR;
            end else if (cnt_n == MAX_CNT) begin
                state_n = ERR;
            end
        end
    end

    // Status flags are flopped alongside the state so every output is registered.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            sel_out <= 2'b00;
            cand    <= 4'b1111;
            cnt     <= 4'd0;
        end else begin
            state   <= state_n;
            busy    <= (state_n == SCAN);
            done    <= (state_n == DONE);
            err     <= (state_n == ERR);
            sel_out <= sel_n;
            cand    <= cand_n;
            cnt     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_fn_sw_4_id.sv
// Randomised and directed bench for fn_sw_4_id against a behavioural model
// that filters the four candidate functions directly.
module tb_fn_sw_4_id;

    localparam int MAX_SMP = 8;

    logic       clk;
    logic       res;
    logic       start;
    logic       vld;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] sel_out;
    logic [3:0] cand;
    logic [3:0] cnt;

    int vectors;
    int miscompares;

    // Reference model: a phase flag per outcome, a candidate mask, a sample count.
    logic       m_busy;
    logic       m_done;
    logic       m_err;
    logic [1:0] m_sel;
    logic [3:0] m_cand;
    int         m_cnt;

    fn_sw_4_id #(.MAX_SMP(MAX_SMP)) dut (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .vld     (vld),
        .a       (a),
        .b       (b),
        .y       (y),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .sel_out (sel_out),
        .cand    (cand),
        .cnt     (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic fn(input int sel, input logic fa, input logic fb);
        case (sel)
            0:       return fa & fb;
            1:       return fa | fb;
            2:       return fa ^ fb;
            default: return ~(fa ^ fb);
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {busy, done, err, sel_out, cand, cnt};
    endfunction

    function automatic logic [12:0] expected();
        return {m_busy, m_done, m_err, m_sel, m_cand, 4'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_sel = 0; m_cand = 4'b1111; m_cnt = 0;
    endtask

    task automatic model_step(input logic st, input logic v, input logic sa,
                              input logic sb, input logic sy);
        logic [3:0] keep;
        int         survivors;
        if (st) begin
            m_busy = 1; m_done = 0; m_err = 0; m_sel = 0; m_cand = 4'b1111; m_cnt = 0;
        end else if (m_busy && v) begin
            keep = m_cand;
            for (int s = 0; s < 4; s++)
                if (fn(s, sa, sb) != sy) keep[s] = 1'b0;
            m_cand    = keep;
            m_cnt     = m_cnt + 1;
            survivors = $countones(keep);
            if (survivors == 1) begin
                m_busy = 0; m_done = 1;
                for (int s = 0; s < 4; s++)
                    if (keep[s]) m_sel = 2'(s);
            end else if (survivors == 0 || m_cnt == MAX_SMP) begin
                m_busy = 0; m_err = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic applyStimulus(input logic st, input logic v, input logic sa,
                                 input logic sb, input logic sy);
        start = st; vld = v; a = sa; b = sb; y = sy;
        model_step(st, v, sa, sb, sy);
        @(posedge clk);
        #1;
        start = 0; vld = 0;
    endtask

    task automatic test_reset();
        res = 1; start = 0; vld = 0; a = 0; b = 0; y = 0;
        model_reset();
        #3;
        vectors++;
        if (observed() !== 13'b000_00_1111_0000) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b want %b", observed(), 13'b000_00_1111_0000);
        end
        @(posedge clk); #1;
        res = 0;
        applyStimulus(0, 1, 1, 1, 1);
        vectors++;
        if (observed() !== expected()) begin
            miscompares++;
            $display("[TB] FAIL idle_ignores_vld got %b want %b", observed(), expected());
        end
    endtask

    task automatic run_table(input string name, input logic [4:0] tbl[$]);
        foreach (tbl[i]) begin
            applyStimulus(tbl[i][4], tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL %s step %0d got %b want %b", name, i, observed(), expected());
            end
        end
    endtask

    task automatic test_and_run();
        logic [4:0] tbl[$] = '{5'b10000, 5'b01000, 5'b01010, 5'b01111};
        run_table("and_run", tbl);
        vectors++;
        if ({done, sel_out, cand, cnt} !== {1'b1, 2'b00, 4'b0001, 4'd2}) begin
            miscompares++;
            $display("[TB] FAIL and_result got %b want %b", {done, sel_out, cand, cnt},
                     {1'b1, 2'b00, 4'b0001, 4'd2});
        end
    endtask

    task automatic test_xnor_run();
        logic [4:0] tbl[$] = '{5'b10000, 5'b01111, 5'b01010, 5'b01001};
        run_table("xnor_run", tbl);
        vectors++;
        if ({done, sel_out, cand, cnt} !== {1'b1, 2'b11, 4'b1000, 4'd3}) begin
            miscompares++;
            $display("[TB] FAIL xnor_result got %b want %b", {done, sel_out, cand, cnt},
                     {1'b1, 2'b11, 4'b1000, 4'd3});
        end
    endtask

    task automatic test_inconsistent();
        logic [4:0] tbl[$] = '{5'b10000, 5'b01011, 5'b01100, 5'b01111};
        run_table("inconsistent", tbl);
        vectors++;
        if ({busy, done, err, cand, cnt} !== {3'b001, 4'b0000, 4'd2}) begin
            miscompares++;
            $display("[TB] FAIL inconsistent_result got %b want %b", {busy, done, err, cand, cnt},
                     {3'b001, 4'b0000, 4'd2});
        end
    endtask

    task automatic test_timeout();
        logic [4:0] tbl[$];
        tbl.push_back(5'b10000);
        for (int i = 0; i < MAX_SMP; i++) begin
            tbl.push_back(5'b01111);
            tbl.push_back(5'b00000);
        end
        run_table("timeout", tbl);
        vectors++;
        if ({err, cand, cnt} !== {1'b1, 4'b1011, 4'(MAX_SMP)}) begin
            miscompares++;
            $display("[TB] FAIL timeout_result got %b want %b", {err, cand, cnt},
                     {1'b1, 4'b1011, 4'(MAX_SMP)});
        end
        // Resolving on the final allowed accept must give DONE, not a timeout.
        tbl.delete();
        tbl.push_back(5'b10000);
        for (int i = 0; i < MAX_SMP - 1; i++) tbl.push_back(5'b01111);
        tbl.push_back(5'b01011);
        run_table("last_accept", tbl);
        vectors++;
        if ({done, err, sel_out, cnt} !== {2'b10, 2'b01, 4'(MAX_SMP)}) begin
            miscompares++;
            $display("[TB] FAIL last_accept_done got %b want %b", {done, err, sel_out, cnt},
                     {2'b10, 2'b01, 4'(MAX_SMP)});
        end
    endtask

    task automatic test_restart();
        logic [4:0] tbl[$] = '{5'b10000, 5'b01000, 5'b11011, 5'b01000, 5'b01010,
                               5'b10000, 5'b01011};
        run_table("restart", tbl);
        vectors++;
        if ({busy, cand, cnt} !== {1'b1, 4'b0110, 4'd1}) begin
            miscompares++;
            $display("[TB] FAIL restart_result got %b want %b", {busy, cand, cnt},
                     {1'b1, 4'b0110, 4'd1});
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] tbl[$] = '{5'b10000, 5'b01000};
        run_table("pre_reset", tbl);
        #2;
        res = 1;
        model_reset();
        #1;
        vectors++;
        if (observed() !== 13'b000_00_1111_0000) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %b want %b", observed(), 13'b000_00_1111_0000);
        end
        @(posedge clk); #1;
        res = 0;
        tbl = '{5'b10000, 5'b01000, 5'b01010};
        run_table("post_reset", tbl);
    endtask

    task automatic test_random();
        int hsel;
        logic st, v, sa, sb, sy;
        hsel = $urandom_range(0, 3);
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 11) == 0);
            if (st) hsel = $urandom_range(0, 3);
            v  = ($urandom_range(0, 3) != 0);
            sa = 1'($urandom);
            sb = 1'($urandom);
            sy = fn(hsel, sa, sb) ^ ($urandom_range(0, 24) == 0);
            applyStimulus(st, v, sa, sb, sy);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("[TB] FAIL random step %0d got %b want %b", i, observed(), expected());
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_and_run();
        test_xnor_run();
        test_inconsistent();
        test_timeout();
        test_restart();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
